// File: rtl/sap_1_pkg.sv
// SAP-1 control unit shared definitions.
// Sequencer states, T-state ring constants, ROM address defaults.
package sap_1_pkg;

  localparam int SAP_ADDR_W = 8;
  localparam logic [SAP_ADDR_W-1:0] SAP_FETCH_BASE = 8'h00;

  localparam int SAP_T_W = 6;
  localparam logic [SAP_T_W-1:0] T1 = 6'b000001;
  localparam logic [SAP_T_W-1:0] T2 = 6'b000010;
  localparam logic [SAP_T_W-1:0] T3 = 6'b000100;
  localparam logic [SAP_T_W-1:0] T4 = 6'b001000;
  localparam logic [SAP_T_W-1:0] T5 = 6'b010000;
  localparam logic [SAP_T_W-1:0] T6 = 6'b100000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } sap_1_state_t;

endpackage

// File: rtl/sap_1_presettable_counter.sv
// Presettable modulo counter holding the control-ROM address.
// Async clear, enable, synchronous load beats increment.
module sap_1_presettable_counter
  import sap_1_pkg::*;
#(
  parameter int W = SAP_ADDR_W,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load or wrap-around increment on enabled edges.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= load ? d : q + W'(1);
    end
  end

endmodule

// File: rtl/sap_1_microprogram_sequencer.sv
// SAP-1 control-ROM sequencer: fetch routine, mapped
// execute routine, one-hot T-state ring and HLT freeze.
module sap_1_microprogram_sequencer
  import sap_1_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter logic [ADDR_W-1:0] FETCH_BASE = SAP_FETCH_BASE,
  parameter int FETCH_LEN = 3,
  parameter int EXEC_LEN = 3
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          run,
  input  logic [ADDR_W-1:0]             map_addr,
  input  logic                          halt,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic [FETCH_LEN+EXEC_LEN-1:0] t_state,
  output logic                          fetch,
  output logic                          map_load,
  output logic                          halted
);

  localparam int T_W = FETCH_LEN + EXEC_LEN;
  localparam logic [T_W-1:0] ST_T1 = {{(T_W-1){1'b0}}, 1'b1};
  localparam logic [T_W-1:0] ST_TF = ST_T1 << (FETCH_LEN - 1);
  localparam logic [T_W-1:0] ST_TX = ST_T1 << FETCH_LEN;
  localparam logic [T_W-1:0] ST_TL = ST_T1 << (T_W - 1);

  sap_1_state_t state, state_n;
  logic [T_W-1:0] t_n, t_rot;
  logic cnt_en, cnt_ld;
  logic [ADDR_W-1:0] cnt_d;

  assign t_rot = {t_state[T_W-2:0], t_state[T_W-1]};

  sap_1_presettable_counter #(
    .W       (ADDR_W),
    .RST_VAL (FETCH_BASE)
  ) u_cnt (
    .clk     (clk),
    .clear_n (clr_n),
    .en      (cnt_en),
    .load    (cnt_ld),
    .d       (cnt_d),
    .q       (rom_addr)
  );

  // State and T-state ring registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= FETCH;
      t_state <= ST_T1;
    end else begin
      state   <= state_n;
      t_state <= t_n;
    end
  end

  // Next state, ring advance and address counter control.
  always_comb begin
    state_n = state;
    t_n     = t_state;
    cnt_en  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_d   = FETCH_BASE;
    if (run && state != HALT) begin
      if (!$onehot(t_state)) begin
        state_n = FETCH;
        t_n     = ST_T1;
        cnt_en  = 1'b1;
        cnt_ld  = 1'b1;
      end else begin
        unique case (state)
          FETCH: begin
            cnt_en = 1'b1;
            if (t_state == ST_TF) begin
              state_n = EXEC;
              t_n     = ST_TX;
              cnt_ld  = 1'b1;
              cnt_d   = map_addr;
            end else begin
              t_n = t_rot;
            end
          end
          EXEC: begin
            if (t_state == ST_TX && halt) begin
              state_n = HALT;
            end else if (t_state == ST_TL) begin
              state_n = FETCH;
              t_n     = ST_T1;
              cnt_en  = 1'b1;
              cnt_ld  = 1'b1;
            end else begin
              t_n    = t_rot;
              cnt_en = 1'b1;
            end
          end
          HALT: begin
            state_n = HALT;
          end
          default: begin
            state_n = FETCH;
            t_n     = ST_T1;
            cnt_en  = 1'b1;
            cnt_ld  = 1'b1;
          end
        endcase
      end
    end
  end

  assign fetch    = |t_state[FETCH_LEN-1:0];
  assign map_load = (state == FETCH) && (t_state == ST_TF);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_sap_1_microprogram_sequencer.sv
// Scoreboard bench for the SAP-1 sequencer: directed steps
// queue expected outputs, a monitor pops and compares them.
module tb_sap_1_microprogram_sequencer;

  typedef struct {
    logic [7:0] addr;
    logic [5:0] t;
    logic       ml;
    logic       h;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       run = 1'b1;
  logic [7:0] map_addr = 8'h03;
  logic       halt = 1'b0;
  logic [7:0] rom_addr;
  logic [5:0] t_state;
  logic       fetch;
  logic       map_load;
  logic       halted;

  exp_t sb[$];
  event ev;
  int n_cmp = 0;
  int n_bad = 0;

  sap_1_microprogram_sequencer dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .run      (run),
    .map_addr (map_addr),
    .halt     (halt),
    .rom_addr (rom_addr),
    .t_state  (t_state),
    .fetch    (fetch),
    .map_load (map_load),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] a, input logic [5:0] t,
                      input logic ml, input logic h, input string nm);
    exp_t e;
    e.addr = a;
    e.t    = t;
    e.ml   = ml;
    e.h    = h;
    e.nm   = nm;
    sb.push_back(e);
    ->ev;
  endtask

  // Drive inputs for the coming edge, expect current outputs.
  task automatic step(input logic r, input logic [7:0] m,
                      input logic hl, input logic [7:0] a,
                      input logic [5:0] t, input logic ml,
                      input logic h, input string nm);
    @(negedge clk);
    run = r;
    map_addr = m;
    halt = hl;
    #1;
    push(a, t, ml, h, nm);
  endtask

  // Assert reset mid-phase; outputs must clear before any edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    run = 1'b1;
    halt = 1'b0;
    clr_n = 1'b0;
    #1;
    push(8'h00, 6'h01, 1'b0, 1'b0, nm);
    #2;
    clr_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic ok;
    forever begin
      @(ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        ok = (rom_addr == e.addr) && (t_state == e.t) &&
             (map_load == e.ml) && (halted == e.h) &&
             (fetch == (|e.t[2:0]));
        if (!ok) begin
          n_bad++;
          $display("FAIL %s: got addr=%h t=%b ml=%b h=%b f=%b exp addr=%h t=%b ml=%b h=%b",
                   e.nm, rom_addr, t_state, map_load, halted, fetch,
                   e.addr, e.t, e.ml, e.h);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int budget;
    do_reset("reset");
    // Basic instruction with map 03
    step(1, 8'h03, 0, 8'h01, 6'h02, 0, 0, "t1_T2");
    step(1, 8'h03, 0, 8'h02, 6'h04, 1, 0, "t1_T3");
    step(1, 8'h03, 0, 8'h03, 6'h08, 0, 0, "t1_T4");
    step(1, 8'h03, 0, 8'h04, 6'h10, 0, 0, "t1_T5");
    step(1, 8'h03, 0, 8'h05, 6'h20, 0, 0, "t1_T6");
    // map_addr only sampled on the T3 edge
    step(1, 8'h30, 0, 8'h00, 6'h01, 0, 0, "t2_T1");
    step(1, 8'h30, 0, 8'h01, 6'h02, 0, 0, "t2_T2");
    step(1, 8'h0C, 0, 8'h02, 6'h04, 1, 0, "t2_T3");
    step(1, 8'h30, 0, 8'h0C, 6'h08, 0, 0, "t2_T4");
    step(1, 8'h30, 0, 8'h0D, 6'h10, 0, 0, "t2_T5");
    step(1, 8'h30, 0, 8'h0E, 6'h20, 0, 0, "t2_T6");
    // Execute address wrap
    step(1, 8'hFE, 0, 8'h00, 6'h01, 0, 0, "t3_T1");
    step(1, 8'hFE, 0, 8'h01, 6'h02, 0, 0, "t3_T2");
    step(1, 8'hFE, 0, 8'h02, 6'h04, 1, 0, "t3_T3");
    step(1, 8'hFE, 0, 8'hFE, 6'h08, 0, 0, "t3_T4");
    step(1, 8'hFE, 0, 8'hFF, 6'h10, 0, 0, "t3_T5");
    step(1, 8'hFE, 0, 8'h00, 6'h20, 0, 0, "t3_T6");
    // Stall in T5
    step(1, 8'h0F, 0, 8'h00, 6'h01, 0, 0, "t4_T1");
    step(1, 8'h0F, 0, 8'h01, 6'h02, 0, 0, "t4_T2");
    step(1, 8'h0F, 0, 8'h02, 6'h04, 1, 0, "t4_T3");
    step(1, 8'h0F, 0, 8'h0F, 6'h08, 0, 0, "t4_T4");
    step(0, 8'h0F, 0, 8'h10, 6'h10, 0, 0, "t4_stall0");
    step(0, 8'h0F, 1, 8'h10, 6'h10, 0, 0, "t4_stall1");
    step(0, 8'h55, 0, 8'h10, 6'h10, 0, 0, "t4_stall2");
    step(0, 8'h0F, 0, 8'h10, 6'h10, 0, 0, "t4_stall3");
    step(1, 8'h0F, 0, 8'h10, 6'h10, 0, 0, "t4_resume");
    step(1, 8'h0F, 0, 8'h11, 6'h20, 0, 0, "t4_T6");
    // Halt on a stalled T4 edge and at T5 is ignored
    step(1, 8'h0F, 0, 8'h00, 6'h01, 0, 0, "t6_T1");
    step(1, 8'h0F, 0, 8'h01, 6'h02, 0, 0, "t6_T2");
    step(1, 8'h0F, 0, 8'h02, 6'h04, 1, 0, "t6_T3");
    step(0, 8'h0F, 1, 8'h0F, 6'h08, 0, 0, "t6_T4_stall");
    step(1, 8'h0F, 0, 8'h0F, 6'h08, 0, 0, "t6_T4_run");
    step(1, 8'h0F, 1, 8'h10, 6'h10, 0, 0, "t6_T5_halt");
    step(1, 8'h0F, 1, 8'h11, 6'h20, 0, 0, "t6_T6");
    // Halt at T4, frozen, then async clear
    step(1, 8'h0F, 0, 8'h00, 6'h01, 0, 0, "t5_T1");
    step(1, 8'h0F, 0, 8'h01, 6'h02, 0, 0, "t5_T2");
    step(1, 8'h0F, 0, 8'h02, 6'h04, 1, 0, "t5_T3");
    step(1, 8'h0F, 1, 8'h0F, 6'h08, 0, 0, "t5_T4");
    for (int i = 0; i < 22; i++) begin
      step(logic'(i % 2), 8'hA5, logic'(i % 3 == 0),
           8'h0F, 6'h08, 0, 1, $sformatf("t5_hold%0d", i));
    end
    do_reset("t5_clear");
    step(1, 8'h0F, 0, 8'h01, 6'h02, 0, 0, "t5_after_T2");
    step(1, 8'h0F, 0, 8'h02, 6'h04, 1, 0, "t5_after_T3");
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
